// File: rtl/dcache_mem_responder.sv
// dcache_mem_responder
// Serves dcache line refills and writebacks by splitting each 128-bit line
// into four 32-bit word beats on a request/grant backing-memory port.
// Refills allow a single read beat in flight. The line is returned on mvalid
// and held until dready.
// Optional feature: define DMEM_RESP_WR_ACK_EN to add a WACK state. In that
// state each writeback is acknowledged with an mvalid pulse, with mdata = 0,
// held until dready.
module dcache_mem_responder (
    input  logic         clk,
    input  logic         rst,
    input  logic         dvalid,
    input  logic [31:0]  addr,
    input  logic         wen,
    input  logic [127:0] ddata,
    input  logic         dready,
    output logic         mready,
    output logic         mvalid,
    output logic [127:0] mdata,
    output logic         sram_req,
    output logic         sram_wen,
    output logic [31:0]  sram_addr,
    output logic [31:0]  sram_wdata,
    input  logic         sram_gnt,
    input  logic         sram_rvalid,
    input  logic [31:0]  sram_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_REQ,
        RD_WAIT,
        RESP
`ifdef DMEM_RESP_WR_ACK_EN
        , WACK
`endif
    } state_t;

    state_t         state_reg;
    logic [1:0]     beat_reg;
    logic [27:0]    line_addr_reg;
    logic [127:0]   wr_buf_reg;
    logic [127:0]   line_buf_reg;

    logic [1:0]     beat_next;
    logic [31:0]    wr_word [4];

    // Low address bits are ignored because requests are always line aligned.
    logic           unused_addr_bits;
    assign unused_addr_bits = ^addr[3:0];

    assign beat_next = beat_reg + 2'd1;

    // Split the captured writeback line into per-beat words.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_wr_word
            assign wr_word[gi] = wr_buf_reg[32*gi +: 32];
        end
    endgenerate

    // Main controller. All outputs are registered and take the value of the
    // state being entered, so they stay stable through any stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            beat_reg      <= 2'd0;
            line_addr_reg <= 28'd0;
            wr_buf_reg    <= 128'd0;
            line_buf_reg  <= 128'd0;
            mready        <= 1'b1;
            mvalid        <= 1'b0;
            mdata         <= 128'd0;
            sram_req      <= 1'b0;
            sram_wen      <= 1'b0;
            sram_addr     <= 32'd0;
            sram_wdata    <= 32'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // mready is high here, so dvalid alone means accept.
                    if (dvalid) begin
                        line_addr_reg <= addr[31:4];
                        wr_buf_reg    <= ddata;
                        beat_reg      <= 2'd0;
                        mready        <= 1'b0;
                        sram_req      <= 1'b1;
                        sram_wen      <= wen;
                        sram_addr     <= {addr[31:4], 4'b0000};
                        sram_wdata    <= wen ? ddata[31:0] : 32'd0;
                        state_reg     <= wen ? WR : RD_REQ;
                    end
                end
                WR: begin
                    if (sram_gnt) begin
                        if (beat_reg == 2'd3) begin
                            beat_reg  <= 2'd0;
                            sram_req  <= 1'b0;
                            sram_wen  <= 1'b0;
`ifdef DMEM_RESP_WR_ACK_EN
                            mvalid    <= 1'b1;
                            mdata     <= 128'd0;
                            state_reg <= WACK;
`else
                            mready    <= 1'b1;
                            state_reg <= IDLE;
`endif
                        end else begin
                            beat_reg   <= beat_next;
                            sram_addr  <= {line_addr_reg, beat_next, 2'b00};
                            sram_wdata <= wr_word[beat_next];
                        end
                    end
                end
                RD_REQ: begin
                    // Drop the request once granted so only one read is in flight.
                    if (sram_gnt) begin
                        sram_req  <= 1'b0;
                        state_reg <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (sram_rvalid) begin
                        line_buf_reg[{beat_reg, 5'd0} +: 32] <= sram_rdata;
                        if (beat_reg == 2'd3) begin
                            beat_reg  <= 2'd0;
                            mvalid    <= 1'b1;
                            mdata     <= {sram_rdata, line_buf_reg[95:0]};
                            state_reg <= RESP;
                        end else begin
                            beat_reg  <= beat_next;
                            sram_req  <= 1'b1;
                            sram_addr <= {line_addr_reg, beat_next, 2'b00};
                            state_reg <= RD_REQ;
                        end
                    end
                end
                RESP: begin
                    if (dready) begin
                        mvalid    <= 1'b0;
                        mready    <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
`ifdef DMEM_RESP_WR_ACK_EN
                WACK: begin
                    if (dready) begin
                        mvalid    <= 1'b0;
                        mready    <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
`endif
                default: begin
                    state_reg <= IDLE;
                    beat_reg  <= 2'd0;
                    mready    <= 1'b1;
                    mvalid    <= 1'b0;
                    sram_req  <= 1'b0;
                    sram_wen  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_mem_responder.sv
// Directed bench for dcache_mem_responder. The bench includes a small
// backing-memory model. Its grant stall is programmable and its read data
// comes back one cycle after the grant. It can also drop one beat's read
// data. Define DMEM_RESP_WR_ACK_EN to check the write-ack build.
module tb_dcache_mem_responder;

    logic         clk = 1'b0;
    logic         rst;
    logic         dvalid;
    logic [31:0]  addr;
    logic         wen;
    logic [127:0] ddata;
    logic         dready;
    logic         mready;
    logic         mvalid;
    logic [127:0] mdata;
    logic         sram_req;
    logic         sram_wen;
    logic [31:0]  sram_addr;
    logic [31:0]  sram_wdata;
    logic         sram_gnt;
    logic         sram_rvalid;
    logic [31:0]  sram_rdata;

    int total = 0;
    int bad = 0;

    // memory model state
    logic [3:0]   wait_cnt;
    int           gnt_stall;
    logic         drop_en;
    logic [1:0]   drop_beat;
    logic         rvalid_m;
    logic [31:0]  rdata_m;
    logic         rvalid_f;
    logic [31:0]  rdata_f;
    logic [31:0]  mem [64];
    logic [31:0]  gnt_addr_q [$];
    logic [31:0]  wr_data_q [$];
    int           acc_cnt = 0;

    always #5 clk = ~clk;

    dcache_mem_responder dut (
        .clk        (clk),
        .rst        (rst),
        .dvalid     (dvalid),
        .addr       (addr),
        .wen        (wen),
        .ddata      (ddata),
        .dready     (dready),
        .mready     (mready),
        .mvalid     (mvalid),
        .mdata      (mdata),
        .sram_req   (sram_req),
        .sram_wen   (sram_wen),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_gnt   (sram_gnt),
        .sram_rvalid(sram_rvalid),
        .sram_rdata (sram_rdata)
    );

    // Grant is held high (even with no request) when stall is 0. Otherwise
    // it rises after sram_req has waited gnt_stall cycles.
    assign sram_gnt    = (int'(wait_cnt) >= gnt_stall);
    assign sram_rvalid = rvalid_m | rvalid_f;
    assign sram_rdata  = rvalid_f ? rdata_f : rdata_m;

    // Backing-memory model and transaction logging
    always @(posedge clk) begin
        if (rst) begin
            wait_cnt <= 4'd0;
            rvalid_m <= 1'b0;
            rdata_m  <= 32'd0;
        end else begin
            wait_cnt <= (sram_req && !sram_gnt) ? wait_cnt + 4'd1 : 4'd0;
            rvalid_m <= sram_req && sram_gnt && !sram_wen &&
                        !(drop_en && sram_addr[3:2] == drop_beat);
            rdata_m  <= mem[sram_addr[7:2]];
            if (sram_req && sram_gnt) begin
                gnt_addr_q.push_back(sram_addr);
                if (sram_wen) wr_data_q.push_back(sram_wdata);
            end
            if (dvalid && mready) acc_cnt <= acc_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int unstable;
        int mv_cnt;
        int base;
        logic seen_mv;
        logic found;
        logic prev_req;
        logic prev_gnt;
        logic [31:0] prev_addr;
        logic [127:0] exp_line;
        logic [31:0] exp_w [4];

        exp_line = 128'h00000044_00000033_00000022_00000011;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[12] = 32'h11; mem[13] = 32'h22; mem[14] = 32'h33; mem[15] = 32'h44;
        rst = 1'b1; dvalid = 1'b0; addr = 32'd0; wen = 1'b0; ddata = 128'd0;
        dready = 1'b0; gnt_stall = 0; drop_en = 1'b0; drop_beat = 2'd0;
        rvalid_f = 1'b0; rdata_f = 32'd0;

        // ---- reset values
        repeat (2) @(negedge clk);
        chk("rst_mready", mready, 1);
        chk("rst_mvalid", mvalid, 0);
        chk("rst_mdata", mdata, 0);
        chk("rst_sram_req", sram_req, 0);
        chk("rst_sram_addr", sram_addr, 0);
        chk("rst_sram_wdata", sram_wdata, 0);
        rst = 1'b0;

        // ---- refill, immediate grant/rvalid
        @(negedge clk);
        gnt_addr_q.delete();
        dvalid = 1'b1; addr = 32'h0000_1234; wen = 1'b0; dready = 1'b0;
        @(negedge clk);
        dvalid = 1'b0; lat = 0;
        chk("rf_busy_mready", mready, 0);
        while (!mvalid && lat < 30) begin @(negedge clk); lat++; end
        chk("rf_latency", lat, 8);
        chk("rf_mdata", mdata, exp_line);
        chk("rf_beats", gnt_addr_q.size(), 4);
        for (int i = 0; i < 4 && i < gnt_addr_q.size(); i++)
            chk($sformatf("rf_addr%0d", i), gnt_addr_q[i], 32'h1230 + 32'(4 * i));
        repeat (2) @(negedge clk);
        chk("rf_hold_mvalid", mvalid, 1);
        chk("rf_hold_mdata", mdata, exp_line);
        dready = 1'b1;
        @(negedge clk);
        dready = 1'b0;
        chk("rf_done_mvalid", mvalid, 0);
        chk("rf_done_mready", mready, 1);

        // ---- writeback
        @(negedge clk);
        gnt_addr_q.delete(); wr_data_q.delete();
        dvalid = 1'b1; addr = 32'h8000_0040; wen = 1'b1;
        ddata = {32'h0000_DDDD, 32'h0000_CCCC, 32'h0000_BBBB, 32'h0000_AAAA};
        @(negedge clk);
        dvalid = 1'b0; lat = 0; seen_mv = 1'b0;
`ifdef DMEM_RESP_WR_ACK_EN
        while (!mvalid && lat < 30) begin @(negedge clk); lat++; end
        chk("wb_ack_latency", lat, 4);
        chk("wb_ack_mdata", mdata, 0);
        chk("wb_ack_mready", mready, 0);
        repeat (2) @(negedge clk);
        chk("wb_ack_hold", mvalid, 1);
        dready = 1'b1;
        @(negedge clk);
        dready = 1'b0;
        chk("wb_ack_done_mready", mready, 1);
        chk("wb_ack_done_mvalid", mvalid, 0);
`else
        while (!mready && lat < 30) begin
            if (mvalid) seen_mv = 1'b1;
            @(negedge clk); lat++;
        end
        chk("wb_latency", lat, 4);
        chk("wb_no_mvalid", seen_mv, 0);
`endif
        exp_w[0] = 32'h0000_AAAA; exp_w[1] = 32'h0000_BBBB;
        exp_w[2] = 32'h0000_CCCC; exp_w[3] = 32'h0000_DDDD;
        chk("wb_beats", wr_data_q.size(), 4);
        for (int i = 0; i < 4 && i < wr_data_q.size(); i++) begin
            chk($sformatf("wb_addr%0d", i), gnt_addr_q[i], 32'h8000_0040 + 32'(4 * i));
            chk($sformatf("wb_data%0d", i), wr_data_q[i], exp_w[i]);
        end

        // ---- refill with 3-cycle grant stalls and dready stall
        gnt_stall = 3;
        @(negedge clk);
        gnt_addr_q.delete();
        dvalid = 1'b1; addr = 32'h0000_1234; wen = 1'b0; dready = 1'b0;
        @(negedge clk);
        dvalid = 1'b0; lat = 0; unstable = 0;
        while (!mvalid && lat < 60) begin
            prev_req = sram_req; prev_gnt = sram_gnt; prev_addr = sram_addr;
            @(negedge clk); lat++;
            if (prev_req && !prev_gnt && (sram_addr != prev_addr || !sram_req))
                unstable++;
        end
        chk("st_latency", lat, 20);
        chk("st_addr_stable", unstable, 0);
        chk("st_mdata", mdata, exp_line);
        chk("st_beats", gnt_addr_q.size(), 4);
        if (gnt_addr_q.size() == 4) chk("st_last_addr", gnt_addr_q[3], 32'h123C);
        unstable = 0;
        repeat (5) begin
            @(negedge clk);
            if (!mvalid || mdata != exp_line) unstable++;
        end
        chk("st_resp_stable", unstable, 0);
        dready = 1'b1;
        @(negedge clk);
        dready = 1'b0; mv_cnt = 0; unstable = 0;
        repeat (3) begin
            if (mvalid) mv_cnt++;
            if (!mready) unstable++;
            @(negedge clk);
        end
        chk("st_single_resp", mv_cnt, 0);
        chk("st_idle_held", unstable, 0);
        gnt_stall = 0;

        // ---- reset during RD_WAIT of beat 2
        drop_en = 1'b1; drop_beat = 2'd2;
        @(negedge clk);
        dvalid = 1'b1; addr = 32'h0000_1234; wen = 1'b0; dready = 1'b0;
        @(negedge clk);
        dvalid = 1'b0; lat = 0; found = 1'b0;
        while (!found && lat < 30) begin
            if (!sram_req && sram_addr == 32'h1238) found = 1'b1;
            else begin @(negedge clk); lat++; end
        end
        chk("rs_reached_wait2", found, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rs_mready", mready, 1);
        chk("rs_mvalid", mvalid, 0);
        chk("rs_sram_req", sram_req, 0);
        chk("rs_sram_addr", sram_addr, 0);
        chk("rs_mdata", mdata, 0);
        @(negedge clk);
        rst = 1'b0;
        rvalid_f = 1'b1; rdata_f = 32'hDEAD_BEEF;
        @(negedge clk);
        rvalid_f = 1'b0; mv_cnt = 0; unstable = 0;
        repeat (3) begin
            if (mvalid) mv_cnt++;
            if (!mready || sram_req) unstable++;
            @(negedge clk);
        end
        chk("rs_late_rvalid_mvalid", mv_cnt, 0);
        chk("rs_late_rvalid_idle", unstable, 0);
        drop_en = 1'b0;

        // ---- dvalid held across refill, then a writeback queued behind it
        base = acc_cnt;
        @(negedge clk);
        dvalid = 1'b1; addr = 32'h0000_1234; wen = 1'b0; dready = 1'b0;
        @(negedge clk);
        addr = 32'h8000_0040; wen = 1'b1;
        ddata = {32'h4444_0004, 32'h3333_0003, 32'h2222_0002, 32'h1111_0001};
        wr_data_q.delete();
        lat = 0;
        while (!mvalid && lat < 30) begin @(negedge clk); lat++; end
        chk("bb_first_mdata", mdata, exp_line);
        chk("bb_acc_during_refill", acc_cnt - base, 1);
        repeat (2) @(negedge clk);
        chk("bb_acc_during_resp", acc_cnt - base, 1);
        dready = 1'b1;
        @(negedge clk);
        chk("bb_idle_mready", mready, 1);
        chk("bb_acc_at_idle", acc_cnt - base, 1);
        @(negedge clk);
        dvalid = 1'b0;
        chk("bb_acc_second", acc_cnt - base, 2);
        chk("bb_second_wen", sram_wen, 1);
        chk("bb_second_addr", sram_addr, 32'h8000_0040);
        lat = 0;
        while (!mready && lat < 30) begin @(negedge clk); lat++; end
        dready = 1'b0;
        chk("bb_acc_final", acc_cnt - base, 2);
        exp_w[0] = 32'h1111_0001; exp_w[1] = 32'h2222_0002;
        exp_w[2] = 32'h3333_0003; exp_w[3] = 32'h4444_0004;
        chk("bb_wr_beats", wr_data_q.size(), 4);
        for (int i = 0; i < 4 && i < wr_data_q.size(); i++)
            chk($sformatf("bb_wdata%0d", i), wr_data_q[i], exp_w[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
